// File: rtl/lcd_write_sequencer_pkg.sv
// Shared definitions for the LCD write sequencer: FSM states, register map,
// status bit positions and the slow-command byte set.
package lcd_write_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_e;

  localparam logic [1:0] ADDR_CMD       = 2'd0;
  localparam logic [1:0] ADDR_DAT       = 2'd1;
  localparam logic [1:0] ADDR_CTRL_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL_RD   = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Clear/home commands need the long execution wait on an HD44780.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Small show-ahead FIFO holding {rs, data} bytes; flush has priority over push.
module lcd_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Avalon-MM slave that queues LCD command/data bytes and replays them with
// HD44780 setup / enable / hold / execution timing.
//
// state | meaning
// IDLE  | waiting for enable and a queued byte
// SETUP | rs/data driven, en low
// PULSE | en high
// HOLD  | en low, rs/data still driven
// EXEC  | waiting for the LCD to finish the command
module lcd_write_sequencer
  import lcd_write_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en
);

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, PULSE_CYC),
                                         max_of(HOLD_CYC, EXEC_CYC)), LONG_EXEC_CYC);
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  lcd_state_e    state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          en_q, en_next;
  logic          busy;
  logic          pop;

  logic          enable;
  logic          overflow;
  logic          wr, push, ctrl_wr, flush;
  logic [8:0]    fifo_dout;
  logic          empty, full;
  logic [LW-1:0] level;
  logic [31:0]   status;
  logic          unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign push         = wr & (address == ADDR_CMD || address == ADDR_DAT);
  assign ctrl_wr      = wr & (address == ADDR_CTRL_STAT);
  assign flush        = ctrl_wr & writedata[1];
  assign unused_wdata = ^writedata[31:8];

  lcd_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     ({address == ADDR_DAT, writedata[7:0]}),
    .dout    (fifo_dout),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) enable <= writedata[0];
      if (ctrl_wr && writedata[2])
        overflow <= 1'b1 & 1'b0;
      else if (push && full && !pop && !flush)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rs_q   <= 1'b0;
      data_q <= '0;
      en_q   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      en_q  <= en_next;
      if (pop) {rs_q, data_q} <= fifo_dout;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !empty) begin
          pop        = 1'b1;
          cnt_next   = CW'(SETUP_CYC - 1);
          next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          cnt_next   = CW'(PULSE_CYC - 1);
          next_state = ST_PULSE;
        end else cnt_next = cnt - 1'b1;
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          cnt_next   = CW'(HOLD_CYC - 1);
          next_state = ST_HOLD;
        end else cnt_next = cnt - 1'b1;
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          cnt_next   = is_long_cmd(rs_q, data_q) ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
          next_state = ST_EXEC;
        end else cnt_next = cnt - 1'b1;
      end
      ST_EXEC: begin
        if (cnt == '0) next_state = ST_IDLE;
        else cnt_next = cnt - 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // en is decoded from next_state and registered so the pin never glitches.
  always_comb begin
    busy    = (state != ST_IDLE);
    en_next = (next_state == ST_PULSE);
  end

  always_comb begin
    status                         = '0;
    status[STAT_BUSY]              = busy;
    status[STAT_EMPTY]             = empty;
    status[STAT_FULL]              = full;
    status[STAT_OVERFLOW]          = overflow;
    status[STAT_LEVEL_LSB +: 8]    = {{(8 - LW){1'b0}}, level};
    readdata = '0;
    case (address)
      ADDR_CTRL_STAT: readdata = status;
      ADDR_CTRL_RD:   readdata = {31'b0, enable};
      default:        readdata = '0;
    endcase
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened timing parameters.
module tb_lcd_write_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en;

  int n_cmp = 0;
  int n_mis = 0;

  lcd_write_sequencer #(
    .FIFO_DEPTH(4), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2),
    .EXEC_CYC(10), .LONG_EXEC_CYC(40)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  always #5 clk = ~clk;

  // Pin monitor: records each strobed byte, pulse width, busy run length and
  // the {rs,data} history leading up to each rising edge of lcd_en.
  logic [8:0] emitted[$];
  int         en_run = 0, busy_run = 0, last_pulse = 0, last_busy = 0;
  logic       en_prev = 1'b0, busy_prev = 1'b0, busy_s;
  logic [8:0] cur, h1 = '0, h2 = '0, h3 = '0, rise_d1 = '0, rise_d2 = '0, rise_d3 = '0;

  always @(negedge clk) begin
    cur = {lcd_rs, lcd_data};
    if (lcd_en && !en_prev) begin
      emitted.push_back(cur);
      rise_d1 = h1; rise_d2 = h2; rise_d3 = h3;
    end
    if (lcd_en) en_run++;
    else if (en_prev) begin last_pulse = en_run; en_run = 0; end
    busy_s = (address == 2'd2) ? readdata[0] : busy_prev;
    if (busy_s) busy_run++;
    else if (busy_prev) begin last_busy = busy_run; busy_run = 0; end
    en_prev = lcd_en; busy_prev = busy_s;
    h3 = h2; h2 = h1; h1 = cur;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd2; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); #1;
    chipselect = 1'b1; address = a;
    #1 d = readdata;
    chipselect = 1'b0; address = 2'd2;
  endtask

  task automatic wait_en(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (lcd_en) seen = 1'b1;
    end
  endtask

  logic [31:0] rv;
  int          base;
  bit          got;

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd2; writedata = '0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    check("rst_pins", {21'b0, lcd_rw, lcd_en, lcd_rs, lcd_data}, 32'h0);
    rd(2'd2, rv); check("rst_status", rv, 32'h2);
    rd(2'd3, rv); check("rst_enable", rv, 32'h1);
    rd(2'd0, rv); check("rst_addr0", rv, 32'h0);

    // 1: single data byte
    base = emitted.size();
    wr(2'd1, 32'h41);
    repeat (25) @(negedge clk);
    check("t1_count", emitted.size() - base, 1);
    check("t1_byte", emitted[base], 9'h141);
    check("t1_setup_d1", rise_d1, 9'h141);
    check("t1_setup_d2", rise_d2, 9'h141);
    check("t1_setup_d3", rise_d3, 9'h000);
    check("t1_pulse", last_pulse, 3);
    check("t1_busy", last_busy, 17);

    // 2: clear command gets the long wait, function-set the normal one
    base = emitted.size();
    wr(2'd0, 32'h01);
    repeat (55) @(negedge clk);
    check("t2_clear_busy", last_busy, 2 + 3 + 2 + 40);
    check("t2_clear_byte", emitted[base], 9'h001);
    wr(2'd0, 32'h38);
    repeat (25) @(negedge clk);
    check("t2_fset_busy", last_busy, 17);
    check("t2_fset_byte", emitted[base + 1], 9'h038);

    // 3: 0x2F goes in flight, 0x30..0x33 fill the queue, 0x34 overflows
    base = emitted.size();
    wr(2'd1, 32'h2F);
    for (int i = 0; i < 5; i++) wr(2'd1, 32'h30 + i);
    rd(2'd2, rv); check("t3_status_ovf", rv, 32'h40D);
    wr(2'd2, 32'h5);
    rd(2'd2, rv); check("t3_status_clr", rv, 32'h405);
    rd(2'd3, rv); check("t3_enable", rv, 32'h1);
    repeat (110) @(negedge clk);
    check("t3_count", emitted.size() - base, 5);
    for (int i = 0; i < 5; i++) check("t3_byte", emitted[base + i], 9'h12F + i);
    rd(2'd2, rv); check("t3_status_end", rv, 32'h2);

    // 4: disabled queue holds bytes until re-enabled
    base = emitted.size();
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h50);
    wr(2'd1, 32'h51);
    repeat (30) @(negedge clk);
    check("t4_no_strobe", emitted.size() - base, 0);
    rd(2'd2, rv); check("t4_status", rv, 32'h200);
    rd(2'd3, rv); check("t4_enable", rv, 32'h0);
    wr(2'd2, 32'h1);
    repeat (50) @(negedge clk);
    check("t4_count", emitted.size() - base, 2);
    check("t4_byte0", emitted[base], 9'h150);
    check("t4_byte1", emitted[base + 1], 9'h151);
    rd(2'd2, rv); check("t4_status_end", rv, 32'h2);

    // 5: flush during A's pulse drops B and C, A completes normally
    base = emitted.size();
    wr(2'd1, 32'hA0);
    wr(2'd1, 32'hB0);
    wr(2'd1, 32'hC0);
    wait_en(got);
    check("t5_en_seen", 32'(got), 32'h1);
    wr(2'd2, 32'h3);
    repeat (40) @(negedge clk);
    check("t5_count", emitted.size() - base, 1);
    check("t5_byte", emitted[base], 9'h1A0);
    check("t5_pulse", last_pulse, 3);
    check("t5_busy", last_busy, 17);
    rd(2'd2, rv); check("t5_status", rv, 32'h2);

    // 6: reset while strobing
    wr(2'd1, 32'h60);
    wr(2'd1, 32'h61);
    wait_en(got);
    check("t6_en_seen", 32'(got), 32'h1);
    #2 reset_n = 1'b0;
    #1 check("t6_en_async", {31'b0, lcd_en}, 32'h0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    base = emitted.size();
    rd(2'd2, rv); check("t6_status", rv, 32'h2);
    repeat (40) @(negedge clk);
    check("t6_no_strobe", emitted.size() - base, 0);
    check("t6_pins", {23'b0, lcd_rs, lcd_data}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
